conv_out_reader: RTL and testbench

CONV_OUT_READER -- requirements
Module: conv_out_reader

---
 rtl/conv_pkg.sv | 24 ++
 rtl/conv_out_reader_if.sv | 35 +++
 rtl/conv_out_ram.sv | 36 +++
 rtl/conv_out_reader.sv | 224 ++++++++++++++++++++++
 tb/tb_conv_out_reader.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared types and defaults for the convolution output reader
//
// Purpose : FSM state encoding, default geometry and widths, and a helper that
//           sizes RAM addresses. Every other file in the block imports it.
// Ports   : none (package)
package conv_pkg;

  localparam int DEF_IMG_W = 3;
  localparam int DEF_IMG_H = 3;
  localparam int DEF_DW    = 12;
  localparam int DEF_AW    = 17;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DRAIN   = 2'd2
  } conv_state_e;

  // Address bits needed to index a buffer of 'depth' entries (at least one bit).
  function automatic int addr_bits(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/conv_out_reader_if.sv
// rtl/conv_out_reader_if.sv - write-side and stream-side bus of the output reader
//
// Purpose : bundles the convolution engine write port (wr_en/wr_addr/wr_data,
//           frame_done) and the outgoing pixel stream (m_valid/m_data/m_last,
//           m_ready).
// Modports: master - the reader: consumes writes and m_ready, drives the stream
//           slave  - the surroundings: drive writes and m_ready, observe stream
interface conv_out_reader_if
  import conv_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int AW = DEF_AW
);

  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          frame_done;

  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          m_ready;

  modport master (
    input  wr_en, wr_addr, wr_data, frame_done, m_ready,
    output m_valid, m_data, m_last
  );

  modport slave (
    output wr_en, wr_addr, wr_data, frame_done, m_ready,
    input  m_valid, m_data, m_last
  );

endinterface

// File: rtl/conv_out_ram.sv
// rtl/conv_out_ram.sv - simple dual-port result buffer, DEPTH x DW
//
// Purpose : one write port, one read port with a registered read (data appears
//           the cycle after rd_en). No reset: contents survive rst.
// Ports   : clk               - clock
//           wr_en/wr_addr/wr_data - write port
//           rd_en/rd_addr     - read request
//           rd_data           - read data, valid one cycle after rd_en
module conv_out_ram
  import conv_pkg::*;
#(
  parameter int DW    = DEF_DW,
  parameter int DEPTH = DEF_IMG_W * DEF_IMG_H,
  parameter int RAW   = addr_bits(DEF_IMG_W * DEF_IMG_H)
) (
  input  logic           clk,
  input  logic           wr_en,
  input  logic [RAW-1:0] wr_addr,
  input  logic [DW-1:0]  wr_data,
  input  logic           rd_en,
  input  logic [RAW-1:0] rd_addr,
  output logic [DW-1:0]  rd_data
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/conv_out_reader.sv
// rtl/conv_out_reader.sv - captures a result frame and streams it out in raster order
//
// Purpose : the convolution engine writes pixels by linear address; on
//           frame_done the whole buffer is streamed address 0 first, with
//           m_last on the final pixel. Out-of-range or mistimed traffic sets a
//           sticky err flag.
// Ports   : clk, rst   - clock, synchronous active-high reset
//           bus        - conv_out_reader_if.master (write port + pixel stream)
//           busy       - high while the frame is being streamed
//           err        - sticky protocol error, cleared only by rst
//           checksum   - only with CONV_OUT_CHECKSUM_EN: 16-bit wrapping sum
//                        of pixels accepted in the current/last drain
// Config  : `define CONV_OUT_CHECKSUM_EN adds the checksum port and accumulator.
module conv_out_reader
  import conv_pkg::*;
#(
  parameter int IMG_W = DEF_IMG_W,
  parameter int IMG_H = DEF_IMG_H,
  parameter int DW    = DEF_DW,
  parameter int AW    = DEF_AW
) (
  input  logic              clk,
  input  logic              rst,
  conv_out_reader_if.master bus,
  output logic              busy,
  output logic              err
`ifdef CONV_OUT_CHECKSUM_EN
  ,
  output logic [15:0]       checksum
`endif
);

  localparam int DEPTH = IMG_W * IMG_H;
  localparam int RAW   = addr_bits(DEPTH);
  localparam int PW    = $clog2(DEPTH + 1);

  localparam logic [PW-1:0] PTR_END  = PW'(DEPTH);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
  localparam logic [AW-1:0] ADDR_END = AW'(DEPTH);

  conv_state_e state_q, state_d;

  logic          in_drain;
  logic          addr_ok;
  logic          wr_ok;
  logic          err_set;
  logic          err_q;
  logic          pop;
  logic          enter_drain;
  logic          rd_issue;
  logic [1:0]    occ_after_pop;

  logic [PW-1:0] rd_ptr;
  logic          rd_pending;
  logic          rd_pending_last;
  logic [DW-1:0] ram_q;

  // Output register (what the stream shows) and one skid entry behind it.
  logic          out_valid;
  logic          out_last;
  logic [DW-1:0] out_data;
  logic          skid_valid;
  logic          skid_last;
  logic [DW-1:0] skid_data;

  assign in_drain = (state_q == ST_DRAIN);
  assign addr_ok  = (bus.wr_addr < ADDR_END);
  assign wr_ok    = bus.wr_en & ~in_drain & addr_ok;
  assign err_set  = (bus.wr_en & ~in_drain & ~addr_ok)
                  | (in_drain & (bus.wr_en | bus.frame_done));
  assign pop      = out_valid & bus.m_ready;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      // frame_done straight from IDLE streams whatever the buffer holds.
      ST_IDLE: begin
        if (bus.frame_done) begin
          state_d = ST_DRAIN;
        end else if (bus.wr_en) begin
          state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (bus.frame_done) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (pop && out_last) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign enter_drain = (state_q != ST_DRAIN) && (state_d == ST_DRAIN);

  // ---------------------------------------------------------------------------
  // Read scheduling
  // ---------------------------------------------------------------------------
  // Output register + skid give two slots. A read issued now lands next cycle,
  // so issue only if, after this cycle's pop, at most one slot is committed
  // (held or in flight). That sustains one pixel per cycle with m_ready high
  // and never overruns the skid when m_ready is low.
  always_comb begin
    occ_after_pop = {1'b0, out_valid} + {1'b0, skid_valid}
                  + {1'b0, rd_pending} - {1'b0, pop};
  end

  assign rd_issue = in_drain && (rd_ptr != PTR_END) && (occ_after_pop <= 2'd1);

  conv_out_ram #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .RAW   (RAW)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_ok),
    .wr_addr (bus.wr_addr[RAW-1:0]),
    .wr_data (bus.wr_data),
    .rd_en   (rd_issue),
    .rd_addr (rd_ptr[RAW-1:0]),
    .rd_data (ram_q)
  );

  // ---------------------------------------------------------------------------
  // Read pointer, in-flight tracking, output/skid registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr          <= '0;
      rd_pending      <= 1'b0;
      rd_pending_last <= 1'b0;
      out_valid       <= 1'b0;
      out_last        <= 1'b0;
      out_data        <= '0;
      skid_valid      <= 1'b0;
      skid_last       <= 1'b0;
      skid_data       <= '0;
    end else if (enter_drain) begin
      // The pipeline is already empty outside DRAIN; only the pointer restarts.
      rd_ptr     <= '0;
      rd_pending <= 1'b0;
    end else begin
      rd_pending      <= rd_issue;
      rd_pending_last <= (rd_ptr == PTR_LAST);
      if (rd_issue) begin
        rd_ptr <= rd_ptr + 1'b1;
      end

      if (!out_valid || pop) begin
        // Output slot is free this edge: oldest data moves in.
        if (skid_valid) begin
          out_valid  <= 1'b1;
          out_last   <= skid_last;
          out_data   <= skid_data;
          skid_valid <= rd_pending;
          skid_last  <= rd_pending & rd_pending_last;
          if (rd_pending) begin
            skid_data <= ram_q;
          end
        end else begin
          out_valid <= rd_pending;
          out_last  <= rd_pending & rd_pending_last;
          if (rd_pending) begin
            out_data <= ram_q;
          end
        end
      end else if (rd_pending) begin
        // Stalled: park the arriving word so the output stays stable.
        skid_valid <= 1'b1;
        skid_last  <= rd_pending_last;
        skid_data  <= ram_q;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky error
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (err_set) begin
      err_q <= 1'b1;
    end
  end

`ifdef CONV_OUT_CHECKSUM_EN
  logic [15:0] sum_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q <= '0;
    end else if (enter_drain) begin
      sum_q <= '0;
    end else if (pop) begin
      sum_q <= sum_q + 16'(out_data);
    end
  end

  assign checksum = sum_q;
`endif

  assign bus.m_valid = out_valid;
  assign bus.m_data  = out_data;
  assign bus.m_last  = out_last;
  assign busy        = in_drain;
  assign err         = err_q;

endmodule

// File: tb/tb_conv_out_reader.sv
// tb/tb_conv_out_reader.sv - self-checking bench for conv_out_reader
module tb_conv_out_reader;

  localparam int IMG_W = 3;
  localparam int IMG_H = 3;
  localparam int DW    = 12;
  localparam int AW    = 17;
  localparam int DEPTH = IMG_W * IMG_H;

  logic clk = 1'b0;
  logic rst;
  logic busy;
  logic err;
`ifdef CONV_OUT_CHECKSUM_EN
  logic [15:0] checksum;
`endif

  always #5 clk = ~clk;

  conv_out_reader_if #(.DW(DW), .AW(AW)) bus ();

  conv_out_reader #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .DW    (DW),
    .AW    (AW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .busy     (busy),
    .err      (err)
`ifdef CONV_OUT_CHECKSUM_EN
    ,
    .checksum (checksum)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference model: buffer contents, the frame snapshot being streamed,
  // stream position, sticky error, cycles since drain began.
  logic [DW-1:0] mem_model [DEPTH];
  logic [DW-1:0] exp_frame [DEPTH];
  logic [DW-1:0] got [$];
  bit            draining   = 1'b0;
  bit            m_err      = 1'b0;
  int            exp_idx    = 0;
  int            age        = 0;
  logic [15:0]   sum_model  = '0;
  bit            mon_en     = 1'b0;
  bit            held_ready = 1'b0;

  bit            prev_stall = 1'b0;
  bit            prev_rst   = 1'b0;
  logic [DW-1:0] prev_data  = '0;
  logic          prev_last  = 1'b0;
  logic          pop_s;

  // Compare process: sampled on the falling edge, it checks outputs and then
  // advances the model by the inputs the next rising edge will sample.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        check("busy", busy, draining);
        check("err", err, m_err);
        if (!draining) begin
          check("valid_outside_drain", bus.m_valid, 1'b0);
        end else if (age < 2) begin
          check("valid_early", bus.m_valid, 1'b0);
        end else if (age == 2) begin
          check("valid_first", bus.m_valid, 1'b1);
        end else if (held_ready && exp_idx < DEPTH) begin
          check("no_bubble", bus.m_valid, 1'b1);
        end
        if (prev_stall && !prev_rst) begin
          check("hold_valid", bus.m_valid, 1'b1);
          check("hold_data", bus.m_data, prev_data);
          check("hold_last", bus.m_last, prev_last);
        end
`ifdef CONV_OUT_CHECKSUM_EN
        check("checksum", checksum, sum_model);
`endif
        pop_s = bus.m_valid & bus.m_ready;
        if (pop_s) begin
          if (exp_idx < DEPTH) begin
            check("pix_data", bus.m_data, exp_frame[exp_idx]);
            check("pix_last", bus.m_last, (exp_idx == DEPTH - 1));
          end else begin
            checks++;
            errors++;
            $display("FAIL overrun actual=%0d pixels required=%0d", exp_idx + 1, DEPTH);
          end
          got.push_back(bus.m_data);
          sum_model = sum_model + 16'(bus.m_data);
          exp_idx++;
        end
        prev_stall = bus.m_valid & ~bus.m_ready;
        prev_data  = bus.m_data;
        prev_last  = bus.m_last;
        prev_rst   = rst;

        if (rst) begin
          draining  = 1'b0;
          m_err     = 1'b0;
          exp_idx   = 0;
          sum_model = '0;
        end else if (!draining) begin
          if (bus.wr_en) begin
            if (bus.wr_addr < AW'(DEPTH)) mem_model[int'(bus.wr_addr)] = bus.wr_data;
            else m_err = 1'b1;
          end
          if (bus.frame_done) begin
            draining  = 1'b1;
            exp_frame = mem_model;
            exp_idx   = 0;
            age       = 0;
            sum_model = '0;
            got.delete();
          end
        end else begin
          if (bus.wr_en || bus.frame_done) m_err = 1'b1;
          if (pop_s && exp_idx == DEPTH) draining = 1'b0;
          age++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_px(input int a, input int d);
    bus.wr_en   = 1'b1;
    bus.wr_addr = AW'(a);
    bus.wr_data = DW'(d);
    tick();
    bus.wr_en   = 1'b0;
  endtask

  task automatic pulse_fd();
    bus.frame_done = 1'b1;
    tick();
    bus.frame_done = 1'b0;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // mode 0: ready held high, 1: toggle 1,0,1,0..., 2: random ready.
  task automatic run_drain(input int mode, input bit junk);
    int n = 0;
    while (draining && n < 300) begin
      case (mode)
        0:       bus.m_ready = 1'b1;
        1:       bus.m_ready = (n % 2 == 0);
        default: bus.m_ready = ($urandom_range(0, 2) != 0);
      endcase
      if (junk) begin
        bus.wr_en      = ($urandom_range(0, 9) == 0);
        bus.wr_addr    = AW'($urandom_range(0, DEPTH + 2));
        bus.wr_data    = DW'($urandom);
        bus.frame_done = ($urandom_range(0, 9) == 0);
      end
      tick();
      n++;
    end
    bus.wr_en      = 1'b0;
    bus.frame_done = 1'b0;
    if (draining) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout actual=%0d cycles required=<300", n);
    end
    tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    rst            = 1'b1;
    bus.wr_en      = 1'b0;
    bus.wr_addr    = '0;
    bus.wr_data    = '0;
    bus.frame_done = 1'b0;
    bus.m_ready    = 1'b0;
    tick();
    mon_en = 1'b1;
    tick();
    check("rst_valid", bus.m_valid, 1'b0);
    check("rst_data", bus.m_data, '0);
    check("rst_last", bus.m_last, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_err", err, 1'b0);
    rst = 1'b0;
    tick();

    // Full frame 100..108, ready held high.
    bus.m_ready = 1'b1;
    held_ready  = 1'b1;
    for (int i = 0; i < DEPTH; i++) write_px(i, 100 + i);
    pulse_fd();
    run_drain(0, 1'b0);
    held_ready = 1'b0;
    check("a_count", got.size(), 9);
    check("a_first", got[0], 100);
    check("a_last", got[8], 108);
    check("a_busy_after", busy, 1'b0);
`ifdef CONV_OUT_CHECKSUM_EN
    check("a_checksum", checksum, 16'd936);
`endif

    // Same frame re-streamed from IDLE with toggling ready.
    pulse_fd();
    run_drain(1, 1'b0);
    check("b_count", got.size(), 9);
    check("b_mid", got[4], 104);
    check("b_last", got[8], 108);

    // Out-of-range write during capture: err, buffer untouched.
    write_px(0, 100);
    write_px(9, 12'h555);
    tick();
    check("c_err_set", err, 1'b1);
    bus.m_ready = 1'b1;
    pulse_fd();
    run_drain(0, 1'b0);
    check("c_pix1", got[1], 101);
    check("c_last", got[8], 108);
    check("c_err_sticky", err, 1'b1);
    pulse_rst();
    check("c_err_cleared", err, 1'b0);

    // Final write coincident with frame_done.
    for (int i = 0; i < DEPTH - 1; i++) write_px(i, 100 + i);
    bus.wr_en      = 1'b1;
    bus.wr_addr    = AW'(8);
    bus.wr_data    = 12'hFFF;
    bus.frame_done = 1'b1;
    tick();
    bus.wr_en      = 1'b0;
    bus.frame_done = 1'b0;
    run_drain(0, 1'b0);
    check("d_pix7", got[7], 107);
    check("d_last", got[8], 12'hFFF);

    // Reset after four accepted pixels, then a clean restart.
    bus.m_ready = 1'b1;
    pulse_fd();
    for (int n = 0; n < 40 && got.size() < 4; n++) tick();
    check("e_four_accepted", got.size(), 4);
    pulse_rst();
    check("e_valid_dropped", bus.m_valid, 1'b0);
    check("e_busy_dropped", busy, 1'b0);
    pulse_fd();
    run_drain(0, 1'b0);
    check("e_restart_first", got[0], 100);
    check("e_restart_last", got[8], 12'hFFF);

    // Randomized frames: scattered writes, bad addresses, junk during drain.
    pulse_rst();
    for (int f = 0; f < 8; f++) begin
      int nw = $urandom_range(3, 15);
      for (int k = 0; k < nw; k++) begin
        bus.wr_en   = ($urandom_range(0, 3) != 0);
        bus.wr_addr = AW'($urandom_range(0, DEPTH + 2));
        bus.wr_data = DW'($urandom);
        tick();
      end
      bus.wr_en      = ($urandom_range(0, 1) == 0);
      bus.wr_addr    = AW'($urandom_range(0, DEPTH - 1));
      bus.wr_data    = DW'($urandom);
      bus.frame_done = 1'b1;
      tick();
      bus.wr_en      = 1'b0;
      bus.frame_done = 1'b0;
      run_drain((f % 3 == 0) ? 0 : 2, (f % 2 == 1));
      if (f == 4) pulse_rst();
    end

    bus.m_ready = 1'b0;
    tick();
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
